ex_reg: RTL and testbench

EX_REG -- requirements
Module: ex_reg

---
 rtl/ex_reg_pkg.sv | 27 ++
 rtl/ex_reg_if.sv | 48 ++++
 rtl/ex_reg.sv | 101 ++++++++++
 tb/tb_ex_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_reg_pkg.sv
// Shared widths and opcode/exception encodings for the EX pipeline register.
// Codes are plain constants so every stage can compare against them directly.
package ex_reg_pkg;
    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int REG_ADDR_W  = 5;
    localparam int MEM_OP_W    = 2;
    localparam int CTRL_OP_W   = 2;
    localparam int EXP_W       = 3;
    localparam int OVF_CNT_W   = 8;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 2'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LDW = 2'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_STW = 2'd2;

    localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP  = 2'd0;
    localparam logic [CTRL_OP_W-1:0] CTRL_OP_WRCR = 2'd1;
    localparam logic [CTRL_OP_W-1:0] CTRL_OP_EXRT = 2'd2;

    localparam logic [EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [EXP_W-1:0] ISA_EXP_EXT_INT    = 3'd1;
    localparam logic [EXP_W-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
    localparam logic [EXP_W-1:0] ISA_EXP_OVERFLOW   = 3'd3;
    localparam logic [EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;
    localparam logic [EXP_W-1:0] ISA_EXP_TRAP       = 3'd5;
    localparam logic [EXP_W-1:0] ISA_EXP_PRV_VIO    = 3'd6;
endpackage

// File: rtl/ex_reg_if.sv
// ID/ALU-to-EX bundle: the master drives decode results and pipeline control,
// the slave (the EX register) returns the registered stage contents.
interface ex_reg_if;
    import ex_reg_pkg::*;

    logic [WORD_DATA_W-1:0] alu_out;
    logic                   alu_of;
    logic                   stall;
    logic                   flush;
    logic                   int_detect;
    logic [WORD_ADDR_W-1:0] id_pc;
    logic                   id_en;
    logic                   id_br_flag;
    logic [MEM_OP_W-1:0]    id_mem_op;
    logic [WORD_DATA_W-1:0] id_mem_wr_data;
    logic [CTRL_OP_W-1:0]   id_ctrl_op;
    logic [REG_ADDR_W-1:0]  id_dst_addr;
    logic                   id_gpr_we_;
    logic [EXP_W-1:0]       id_exp_code;

    logic [WORD_ADDR_W-1:0] ex_pc;
    logic                   ex_en;
    logic                   ex_br_flag;
    logic [MEM_OP_W-1:0]    ex_mem_op;
    logic [WORD_DATA_W-1:0] ex_mem_wr_data;
    logic [CTRL_OP_W-1:0]   ex_ctrl_op;
    logic [REG_ADDR_W-1:0]  ex_dst_addr;
    logic                   ex_gpr_we_;
    logic [EXP_W-1:0]       ex_exp_code;
    logic [WORD_DATA_W-1:0] ex_out;
    logic [OVF_CNT_W-1:0]   ovf_cnt;

    modport master (
        output alu_out, alu_of, stall, flush, int_detect,
               id_pc, id_en, id_br_flag, id_mem_op, id_mem_wr_data,
               id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
        input  ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data,
               ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out, ovf_cnt
    );

    modport slave (
        input  alu_out, alu_of, stall, flush, int_detect,
               id_pc, id_en, id_br_flag, id_mem_op, id_mem_wr_data,
               id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
        output ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data,
               ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out, ovf_cnt
    );
endinterface

// File: rtl/ex_reg.sv
// EX pipeline register: latches ALU result and ID control, converting signed
// overflow into an exception and counting such conversions (saturating).
module ex_reg
    import ex_reg_pkg::*;
(
    input logic    clk,
    input logic    reset,
    ex_reg_if.slave bus
);
    logic [WORD_ADDR_W-1:0] pc_q, pc_d;
    logic                   en_q, en_d;
    logic                   br_flag_q, br_flag_d;
    logic [MEM_OP_W-1:0]    mem_op_q, mem_op_d;
    logic [WORD_DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [CTRL_OP_W-1:0]   ctrl_op_q, ctrl_op_d;
    logic [REG_ADDR_W-1:0]  dst_addr_q, dst_addr_d;
    logic                   gpr_we_q, gpr_we_d;
    logic [EXP_W-1:0]       exp_code_q, exp_code_d;
    logic [WORD_DATA_W-1:0] out_q, out_d;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic                   ovf_conv;

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == {OVF_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // An exception already raised upstream takes precedence over overflow.
    assign ovf_conv = bus.alu_of && bus.id_en && (bus.id_exp_code == ISA_EXP_NO_EXP);

    always_comb begin
        pc_d          = bus.id_pc;
        en_d          = bus.id_en;
        br_flag_d     = bus.id_br_flag;
        mem_op_d      = bus.id_mem_op;
        mem_wr_data_d = bus.id_mem_wr_data;
        ctrl_op_d     = bus.id_ctrl_op;
        dst_addr_d    = bus.id_dst_addr;
        gpr_we_d      = bus.id_gpr_we_;
        exp_code_d    = bus.id_exp_code;
        out_d         = bus.alu_out;
        ovf_cnt_d     = ovf_cnt_q;
        if (bus.flush) begin
            en_d          = 1'b0;
            br_flag_d     = 1'b0;
            mem_op_d      = MEM_OP_NOP;
            mem_wr_data_d = '0;
            ctrl_op_d     = CTRL_OP_NOP;
            dst_addr_d    = '0;
            gpr_we_d      = 1'b1;
            exp_code_d    = ISA_EXP_NO_EXP;
            out_d         = '0;
        end else if (bus.int_detect || ovf_conv) begin
            // Kill side effects; PC and ALU result stay visible for the handler.
            mem_op_d   = MEM_OP_NOP;
            ctrl_op_d  = CTRL_OP_NOP;
            gpr_we_d   = 1'b1;
            exp_code_d = bus.int_detect ? ISA_EXP_EXT_INT : ISA_EXP_OVERFLOW;
            if (!bus.int_detect) ovf_cnt_d = sat_inc(ovf_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= '0;
            en_q          <= 1'b0;
            br_flag_q     <= 1'b0;
            mem_op_q      <= MEM_OP_NOP;
            mem_wr_data_q <= '0;
            ctrl_op_q     <= CTRL_OP_NOP;
            dst_addr_q    <= '0;
            gpr_we_q      <= 1'b1;
            exp_code_q    <= ISA_EXP_NO_EXP;
            out_q         <= '0;
            ovf_cnt_q     <= '0;
        end else if (!bus.stall) begin
            pc_q          <= pc_d;
            en_q          <= en_d;
            br_flag_q     <= br_flag_d;
            mem_op_q      <= mem_op_d;
            mem_wr_data_q <= mem_wr_data_d;
            ctrl_op_q     <= ctrl_op_d;
            dst_addr_q    <= dst_addr_d;
            gpr_we_q      <= gpr_we_d;
            exp_code_q    <= exp_code_d;
            out_q         <= out_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    assign bus.ex_pc          = pc_q;
    assign bus.ex_en          = en_q;
    assign bus.ex_br_flag     = br_flag_q;
    assign bus.ex_mem_op      = mem_op_q;
    assign bus.ex_mem_wr_data = mem_wr_data_q;
    assign bus.ex_ctrl_op     = ctrl_op_q;
    assign bus.ex_dst_addr    = dst_addr_q;
    assign bus.ex_gpr_we_     = gpr_we_q;
    assign bus.ex_exp_code    = exp_code_q;
    assign bus.ex_out         = out_q;
    assign bus.ovf_cnt        = ovf_cnt_q;
endmodule

// File: tb/tb_ex_reg.sv
// Directed bench for ex_reg: each step pushes the predicted stage contents to a
// queue, and after the clock edge the DUT outputs are popped and compared.
module tb_ex_reg;
    import ex_reg_pkg::*;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br;
        logic [MEM_OP_W-1:0]    mem_op;
        logic [WORD_DATA_W-1:0] wr_data;
        logic [CTRL_OP_W-1:0]   ctrl_op;
        logic [REG_ADDR_W-1:0]  dst;
        logic                   we_;
        logic [EXP_W-1:0]       exp_code;
        logic [WORD_DATA_W-1:0] out;
        logic [OVF_CNT_W-1:0]   cnt;
    } st_t;

    localparam st_t RST_ST = '{pc: '0, en: 1'b0, br: 1'b0, mem_op: 2'd0, wr_data: '0,
                               ctrl_op: 2'd0, dst: '0, we_: 1'b1, exp_code: 3'd0,
                               out: '0, cnt: '0};

    logic clk = 1'b0;
    logic reset;
    ex_reg_if bus();

    ex_reg dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    st_t exp_q[$];
    st_t model_st;
    st_t got;
    int  n_cmp = 0;
    int  n_err = 0;

    // Reference behaviour of one edge, from the current inputs and the previous state.
    function automatic st_t predict(input st_t p);
        st_t n;
        logic conv;
        conv = bus.alu_of && bus.id_en && (bus.id_exp_code == 3'd0);
        n = '{pc: bus.id_pc, en: bus.id_en, br: bus.id_br_flag, mem_op: bus.id_mem_op,
              wr_data: bus.id_mem_wr_data, ctrl_op: bus.id_ctrl_op, dst: bus.id_dst_addr,
              we_: bus.id_gpr_we_, exp_code: bus.id_exp_code, out: bus.alu_out, cnt: p.cnt};
        if (reset) n = RST_ST;
        else if (bus.stall) n = p;
        else if (bus.flush) begin
            n = RST_ST;
            n.pc = bus.id_pc;
            n.cnt = p.cnt;
        end else if (bus.int_detect || conv) begin
            n.mem_op = 2'd0;
            n.ctrl_op = 2'd0;
            n.we_ = 1'b1;
            n.exp_code = bus.int_detect ? 3'd1 : 3'd3;
            if (!bus.int_detect && p.cnt != 8'd255) n.cnt = p.cnt + 8'd1;
        end
        return n;
    endfunction

    function automatic st_t sample();
        st_t s;
        s = '{pc: bus.ex_pc, en: bus.ex_en, br: bus.ex_br_flag, mem_op: bus.ex_mem_op,
              wr_data: bus.ex_mem_wr_data, ctrl_op: bus.ex_ctrl_op, dst: bus.ex_dst_addr,
              we_: bus.ex_gpr_we_, exp_code: bus.ex_exp_code, out: bus.ex_out, cnt: bus.ovf_cnt};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input st_t g, input st_t e);
        chk({tag, ".pc"},       64'(g.pc),       64'(e.pc));
        chk({tag, ".en"},       64'(g.en),       64'(e.en));
        chk({tag, ".br"},       64'(g.br),       64'(e.br));
        chk({tag, ".mem_op"},   64'(g.mem_op),   64'(e.mem_op));
        chk({tag, ".wr_data"},  64'(g.wr_data),  64'(e.wr_data));
        chk({tag, ".ctrl_op"},  64'(g.ctrl_op),  64'(e.ctrl_op));
        chk({tag, ".dst"},      64'(g.dst),      64'(e.dst));
        chk({tag, ".gpr_we_"},  64'(g.we_),      64'(e.we_));
        chk({tag, ".exp_code"}, 64'(g.exp_code), 64'(e.exp_code));
        chk({tag, ".out"},      64'(g.out),      64'(e.out));
        chk({tag, ".ovf_cnt"},  64'(g.cnt),      64'(e.cnt));
    endtask

    // Predict, clock, then pop and compare one full stage snapshot.
    task automatic step(input string tag);
        st_t e;
        model_st = predict(model_st);
        exp_q.push_back(model_st);
        @(posedge clk);
        #1;
        got = sample();
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_all(tag, got, e);
        end
    endtask

    task automatic idle();
        bus.alu_out = '0; bus.alu_of = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.int_detect = 1'b0; bus.id_pc = '0; bus.id_en = 1'b0; bus.id_br_flag = 1'b0;
        bus.id_mem_op = '0; bus.id_mem_wr_data = '0; bus.id_ctrl_op = '0;
        bus.id_dst_addr = '0; bus.id_gpr_we_ = 1'b1; bus.id_exp_code = '0;
    endtask

    initial begin
        st_t held;
        model_st = RST_ST;
        idle();
        // Reset with junk on the inputs.
        reset = 1'b1;
        bus.id_pc = 30'h155; bus.id_en = 1'b1; bus.alu_out = 32'hDEAD_BEEF; bus.alu_of = 1'b1;
        step("reset");
        chk("reset.direct_gpr_we_", 64'(bus.ex_gpr_we_), 64'd1);
        chk("reset.direct_ovf_cnt", 64'(bus.ovf_cnt), 64'd0);

        // Plain register write.
        reset = 1'b0; idle();
        bus.id_en = 1'b1; bus.alu_out = 32'h0000_0005; bus.id_dst_addr = 5'd3;
        bus.id_gpr_we_ = 1'b0; bus.id_pc = 30'h10; bus.id_br_flag = 1'b1;
        bus.id_ctrl_op = CTRL_OP_WRCR; bus.id_mem_wr_data = 32'h1234_5678;
        step("normal");
        chk("normal.direct_out", 64'(bus.ex_out), 64'd5);
        chk("normal.direct_dst", 64'(bus.ex_dst_addr), 64'd3);

        // Overflow conversion on a store.
        idle();
        bus.id_en = 1'b1; bus.alu_out = 32'h8000_0000; bus.alu_of = 1'b1;
        bus.id_gpr_we_ = 1'b0; bus.id_mem_op = MEM_OP_STW; bus.id_pc = 30'h11;
        step("ovf");
        chk("ovf.direct_exp", 64'(bus.ex_exp_code), 64'd3);
        chk("ovf.direct_mem_op", 64'(bus.ex_mem_op), 64'd0);
        chk("ovf.direct_cnt", 64'(bus.ovf_cnt), 64'd1);

        // Earlier exception wins over overflow.
        bus.id_exp_code = ISA_EXP_UNDEF_INSN; bus.id_pc = 30'h12;
        step("earlier_exp");
        chk("earlier_exp.direct_exp", 64'(bus.ex_exp_code), 64'd2);

        // Invalid slot with overflow flag registers as normal.
        bus.id_exp_code = ISA_EXP_NO_EXP; bus.id_en = 1'b0; bus.id_mem_op = MEM_OP_LDW;
        step("invalid_of");
        chk("invalid_of.direct_cnt", 64'(bus.ovf_cnt), 64'd1);

        // Stall masks flush and overflow for three edges.
        held = sample();
        bus.stall = 1'b1; bus.flush = 1'b1; bus.alu_of = 1'b1; bus.id_en = 1'b1;
        bus.id_pc = 30'h3FF; bus.alu_out = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) step("stall");
        chk_all("stall.direct", sample(), held);

        // Release stall with flush: bubble.
        bus.stall = 1'b0;
        step("flush");
        chk("flush.direct_en", 64'(bus.ex_en), 64'd0);
        chk("flush.direct_gpr_we_", 64'(bus.ex_gpr_we_), 64'd1);

        // Interrupt beats overflow.
        idle();
        bus.int_detect = 1'b1; bus.alu_of = 1'b1; bus.id_en = 1'b1; bus.id_pc = 30'h100;
        bus.id_gpr_we_ = 1'b0; bus.alu_out = 32'h7FFF_FFFF;
        step("int");
        chk("int.direct_exp", 64'(bus.ex_exp_code), 64'd1);
        chk("int.direct_pc", 64'(bus.ex_pc), 64'h100);
        chk("int.direct_cnt", 64'(bus.ovf_cnt), 64'd1);

        // Mixed random traffic.
        for (int i = 0; i < 40; i++) begin
            bus.alu_out = $urandom; bus.alu_of = 1'($urandom_range(0, 1));
            bus.stall = ($urandom_range(0, 7) == 0); bus.flush = ($urandom_range(0, 7) == 0);
            bus.int_detect = ($urandom_range(0, 7) == 0); bus.id_pc = 30'($urandom);
            bus.id_en = 1'($urandom_range(0, 1)); bus.id_br_flag = 1'($urandom_range(0, 1));
            bus.id_mem_op = 2'($urandom_range(0, 2)); bus.id_mem_wr_data = $urandom;
            bus.id_ctrl_op = 2'($urandom_range(0, 2)); bus.id_dst_addr = 5'($urandom);
            bus.id_gpr_we_ = 1'($urandom_range(0, 1));
            bus.id_exp_code = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
            step("random");
        end

        // Drive the counter into saturation.
        idle();
        bus.id_en = 1'b1; bus.alu_of = 1'b1; bus.alu_out = 32'h8000_0001;
        for (int i = 0; i < 260; i++) begin
            bus.id_pc = 30'(i);
            step("sat");
        end
        chk("sat.direct_cnt", 64'(bus.ovf_cnt), 64'd255);
        step("sat_hold");
        chk("sat_hold.direct_cnt", 64'(bus.ovf_cnt), 64'd255);

        // Reset overrides stall.
        reset = 1'b1; bus.stall = 1'b1;
        step("reset_in_stall");
        chk("reset_in_stall.direct_cnt", 64'(bus.ovf_cnt), 64'd0);
        chk("reset_in_stall.direct_exp", 64'(bus.ex_exp_code), 64'd0);

        // First edge after reset behaves normally.
        reset = 1'b0; idle();
        bus.id_en = 1'b1; bus.id_pc = 30'h2A; bus.alu_out = 32'hCAFE_0000;
        bus.id_dst_addr = 5'd31; bus.id_gpr_we_ = 1'b0;
        step("post_reset");
        chk("post_reset.direct_out", 64'(bus.ex_out), 64'hCAFE_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
